// File: rtl/chacha_xor_stream_if.sv
// Byte-stream interface for the ChaCha XOR stage: plaintext/ciphertext in, result out.
// Valid/ready: a byte moves on a rising edge where valid && ready; the sender holds data stable until then.
interface chacha_xor_stream_if;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_last_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_last_o;
  logic       out_ready_i;

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_last_o
  );

  modport master (
    output in_data_i, in_valid_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_last_o
  );
endinterface

// File: rtl/chacha_xor_stream.sv
// Byte-serial XOR stage: fetches 64-byte keystream blocks from the ChaCha generator
// with an incrementing block counter and XORs them with the input byte stream.
module chacha_xor_stream (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      msg_start_i,
  input  logic [31:0]               counter_i,
  chacha_xor_stream_if.slave        strm,
  output logic                      blk_start_o,
  output logic [31:0]               blk_counter_o,
  input  logic                      blk_ready_i,
  input  logic [7:0]                ks_byte_i,
  input  logic                      ks_valid_i,
  output logic                      busy_o,
  output logic                      ovf_o,
  output logic [2:0]                state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FILL  = 3'd2,
    S_XOR   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  buf_q [64];
  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        in_ready;
  logic        accept;
  logic        take;
  logic        buf_we;

  assign accept = in_ready && strm.in_valid_i;
  assign take   = out_valid_q && strm.out_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Keystream buffer holds no control state, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      buf_q[wr_ptr_q] <= ks_byte_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (msg_start_i) state_d = S_REQ;
      S_REQ:   if (blk_ready_i) state_d = S_FILL;
      S_FILL:  if (ks_valid_i && wr_ptr_q == 6'd63) state_d = S_XOR;
      S_XOR: begin
        if (accept) begin
          if (strm.in_last_i)          state_d = S_DRAIN;
          else if (rd_ptr_q == 6'd63)  state_d = S_REQ;
        end
      end
      S_DRAIN: if (take) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: pointers, block counter, output register
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    buf_we      = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (state_q == S_IDLE && msg_start_i) begin
      cnt_d = counter_i;
      ovf_d = 1'b0;
    end
    if (state_q == S_REQ) begin
      wr_ptr_d = '0;
    end
    if (state_q == S_FILL && ks_valid_i) begin
      buf_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 6'd1;
      if (wr_ptr_q == 6'd63) rd_ptr_d = '0;
    end

    // Accept wins over take: a simultaneous take and accept keeps valid high with new data.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = strm.in_data_i ^ buf_q[rd_ptr_q];
      out_last_d  = strm.in_last_i;
      rd_ptr_d    = rd_ptr_q + 6'd1;
      if (!strm.in_last_i && rd_ptr_q == 6'd63) begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'hFFFF_FFFF) ovf_d = 1'b1;
      end
    end else if (take) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    in_ready    = (state_q == S_XOR) && (!out_valid_q || strm.out_ready_i);
    blk_start_o = (state_q == S_REQ) && blk_ready_i;
    busy_o      = (state_q != S_IDLE);
  end

  assign strm.in_ready_o  = in_ready;
  assign strm.out_data_o  = out_data_q;
  assign strm.out_valid_o = out_valid_q;
  assign strm.out_last_o  = out_last_q;
  assign blk_counter_o    = cnt_q;
  assign ovf_o            = ovf_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Bench for chacha_xor_stream: ChaCha20 generator model, randomized byte stream driver,
// and an output scoreboard fed from a keystream reference computed per block.
module tb_chacha_xor_stream;

  logic        clk;
  logic        rst_i;
  logic        msg_start_i;
  logic [31:0] counter_i;
  logic        blk_start_o;
  logic [31:0] blk_counter_o;
  logic        blk_ready_i;
  logic [7:0]  ks_byte_i;
  logic        ks_valid_i;
  logic        busy_o;
  logic        ovf_o;
  logic [2:0]  state_o;

  chacha_xor_stream_if sif ();

  chacha_xor_stream dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .msg_start_i   (msg_start_i),
    .counter_i     (counter_i),
    .strm          (sif),
    .blk_start_o   (blk_start_o),
    .blk_counter_o (blk_counter_o),
    .blk_ready_i   (blk_ready_i),
    .ks_byte_i     (ks_byte_i),
    .ks_valid_i    (ks_valid_i),
    .busy_o        (busy_o),
    .ovf_o         (ovf_o),
    .state_o       (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          blk_seen = 0;
  int          gen_idx  = 0;
  bit          toggle_rdy = 1'b0;
  logic [7:0]  pt [256];
  logic [8:0]  exp_q[$];
  logic [31:0] cnt_exp_q[$];
  logic [7:0]  got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ChaCha20 reference (key 00..1f, nonce 00000000_0000004a_00000000)
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                      input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [31:0] ctr);
    logic [31:0]  st [16];
    logic [31:0]  w  [16];
    logic [511:0] r;
    st[0] = 32'h61707865; st[1] = 32'h3320646e; st[2] = 32'h79622d32; st[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      st[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    st[12] = ctr; st[13] = 32'h0; st[14] = 32'h4a000000; st[15] = 32'h0;
    for (int i = 0; i < 16; i++) w[i] = st[i];
    for (int rnd = 0; rnd < 10; rnd++) begin
      {w[0], w[4], w[8],  w[12]} = qr(w[0], w[4], w[8],  w[12]);
      {w[1], w[5], w[9],  w[13]} = qr(w[1], w[5], w[9],  w[13]);
      {w[2], w[6], w[10], w[14]} = qr(w[2], w[6], w[10], w[14]);
      {w[3], w[7], w[11], w[15]} = qr(w[3], w[7], w[11], w[15]);
      {w[0], w[5], w[10], w[15]} = qr(w[0], w[5], w[10], w[15]);
      {w[1], w[6], w[11], w[12]} = qr(w[1], w[6], w[11], w[12]);
      {w[2], w[7], w[8],  w[13]} = qr(w[2], w[7], w[8],  w[13]);
      {w[3], w[4], w[9],  w[14]} = qr(w[3], w[4], w[9],  w[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + st[i];
    return r;
  endfunction

  // Generator model: accepts a request, goes busy, streams 64 bytes with random gaps.
  initial begin
    logic [511:0] blk;
    logic [31:0]  exp_c;
    blk_ready_i = 1'b1;
    ks_valid_i  = 1'b0;
    ks_byte_i   = '0;
    forever begin
      @(negedge clk);
      if (rst_i && blk_start_o) begin
        check("blk_start_when_ready", blk_ready_i, 1);
        if (blk_ready_i) begin
          blk_seen++;
          if (cnt_exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL blk_counter unexpected request actual=%0h expected=none", blk_counter_o);
            exp_c = blk_counter_o;
          end else begin
            exp_c = cnt_exp_q.pop_front();
            check("blk_counter", blk_counter_o, exp_c);
          end
          blk = chacha_block(exp_c);
          gen_idx = 0;
          @(posedge clk); #1;
          blk_ready_i = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          for (int b = 0; b < 64; b++) begin
            if ($urandom_range(0, 7) == 0) begin
              ks_valid_i = 1'b0;
              @(posedge clk); #1;
            end
            ks_byte_i  = blk[8*b +: 8];
            ks_valid_i = 1'b1;
            gen_idx    = b + 1;
            @(posedge clk); #1;
          end
          ks_valid_i  = 1'b0;
          blk_ready_i = 1'b1;
        end
      end
    end
  end

  // Downstream ready
  initial begin
    sif.out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      sif.out_ready_i = toggle_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor: pops on every take, checks stall stability.
  initial begin
    logic       stall_prev;
    logic [8:0] held;
    logic [8:0] e;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev)
        check("stall_hold", {sif.out_valid_o, sif.out_last_o, sif.out_data_o}, {1'b1, held});
      if (sif.out_valid_o && sif.out_ready_i) begin
        got_q.push_back(sif.out_data_o);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out_byte unexpected actual=%0h expected=none", {sif.out_last_o, sif.out_data_o});
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {sif.out_last_o, sif.out_data_o}, e);
        end
      end
      stall_prev = sif.out_valid_o && !sif.out_ready_i;
      held       = {sif.out_last_o, sif.out_data_o};
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},    sif.in_ready_o,  0);
    check({tag, "_out_valid"},   sif.out_valid_o, 0);
    check({tag, "_out_last"},    sif.out_last_o,  0);
    check({tag, "_out_data"},    sif.out_data_o,  0);
    check({tag, "_blk_start"},   blk_start_o,     0);
    check({tag, "_blk_counter"}, blk_counter_o,   0);
    check({tag, "_busy"},        busy_o,          0);
    check({tag, "_ovf"},         ovf_o,           0);
  endtask

  // Driver: sends pt[0..len-1] as one message and pushes expected output bytes.
  task automatic send_msg(input logic [31:0] c0, input int len, input bit gaps);
    logic [511:0] ks;
    int           nblk;
    int           w;
    bit           exp_ovf;
    nblk = (len + 63) / 64;
    exp_q.delete(); cnt_exp_q.delete(); got_q.delete();
    blk_seen = 0;
    for (int k = 0; k < nblk; k++) cnt_exp_q.push_back(c0 + 32'(k));
    exp_ovf = ({1'b0, c0} + 33'(nblk - 1)) > 33'h0_FFFF_FFFF;
    check("idle_before_start", busy_o, 0);
    msg_start_i = 1'b1;
    counter_i   = c0;
    @(posedge clk); #1;
    msg_start_i = 1'b0;
    counter_i   = $urandom;
    @(negedge clk);
    check("busy_after_start", busy_o, 1);
    @(posedge clk); #1;
    ks = '0;
    for (int i = 0; i < len; i++) begin
      if (i % 64 == 0) ks = chacha_block(c0 + 32'(i / 64));
      if (gaps && $urandom_range(0, 3) == 0) begin
        sif.in_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      sif.in_data_i  = pt[i];
      sif.in_last_i  = (i == len - 1);
      sif.in_valid_i = 1'b1;
      w = 0;
      @(negedge clk);
      while (!sif.in_ready_o && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (!sif.in_ready_o) begin
        check("in_ready_timeout", sif.in_ready_o, 1);
        sif.in_valid_i = 1'b0;
        return;
      end
      exp_q.push_back({sif.in_last_i, pt[i] ^ ks[8*(i%64) +: 8]});
      @(posedge clk); #1;
    end
    sif.in_valid_i = 1'b0;
    sif.in_last_i  = 1'b0;
    w = 0;
    while (busy_o && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("msg_done_idle", busy_o, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("blk_requests", blk_seen, nblk);
    check("ovf", ovf_o, exp_ovf);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) pt[i] = 8'($urandom);
  endtask

  // Stimulus sequence
  initial begin
    string rfc;
    int    w;
    int    len;
    rfc = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    rst_i = 1'b0;
    msg_start_i = 1'b0;
    counter_i = '0;
    sif.in_data_i = '0;
    sif.in_valid_i = 1'b0;
    sif.in_last_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // RFC 8439 2.4.2 message, full throughput then with backpressure
    for (int i = 0; i < 114; i++) pt[i] = rfc[i];
    for (int pass = 0; pass < 2; pass++) begin
      toggle_rdy = (pass == 1);
      send_msg(32'd1, 114, pass == 1);
      check("rfc_ct0", got_q[0], 8'h6e);
      check("rfc_ct1", got_q[1], 8'h2e);
      check("rfc_ct2", got_q[2], 8'h35);
      check("rfc_ct3", got_q[3], 8'h9a);
      check("rfc_count", got_q.size(), 114);
    end

    // Single byte message, then immediate restart
    toggle_rdy = 1'b0;
    pt[0] = 8'h4c;
    send_msg(32'd1, 1, 1'b0);
    check("one_byte", got_q[0], 8'h6e);

    // Counter wrap
    fill_random(65);
    send_msg(32'hFFFF_FFFF, 65, 1'b0);

    // Exactly one block
    fill_random(64);
    send_msg($urandom, 64, 1'b1);

    // Reset during FILL at the 20th keystream byte
    cnt_exp_q.delete();
    cnt_exp_q.push_back(32'd5);
    msg_start_i = 1'b1;
    counter_i   = 32'd5;
    @(posedge clk); #1;
    msg_start_i = 1'b0;
    w = 0;
    while (gen_idx != 20 && w < 500) begin
      @(posedge clk); #2;
      w++;
    end
    check("fill_reach_20", gen_idx, 20);
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midfill_reset");
    @(posedge clk); #1;
    rst_i = 1'b1;
    exp_q.delete();
    cnt_exp_q.delete();
    toggle_rdy = 1'b1;
    fill_random(100);
    send_msg($urandom, 100, 1'b1);

    // Random messages
    for (int m = 0; m < 4; m++) begin
      toggle_rdy = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 160);
      fill_random(len);
      send_msg(($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 1))) : $urandom,
               len, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #400000;
    n_checks++; n_fail++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
